// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - MEM-stage, instruction-fetch and RAM port signals of mem_ctrl
interface mem_ctrl_if;
  logic        ma_ce_flag;
  logic        ma_rw_flag;
  logic [31:0] ma_addr_in;
  logic [7:0]  ma_data_in;
  logic [7:0]  ma_data_out;
  logic        if_ce_in;
  logic [31:0] if_addr_in;
  logic [31:0] if_inst_out;
  logic        if_done_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  ma_ce_flag, ma_rw_flag, ma_addr_in, ma_data_in,
    input  if_ce_in, if_addr_in, mem_din,
    output ma_data_out, if_inst_out, if_done_out, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ma_ce_flag, ma_rw_flag, ma_addr_in, ma_data_in,
    output if_ce_in, if_addr_in, mem_din,
    input  ma_data_out, if_inst_out, if_done_out, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte RAM port arbiter: MEM pass-through with priority, 4-byte
// little-endian instruction fetch burst
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr_q;
  logic [23:0] r_buf;
  logic [31:0] r_inst;
  logic        r_done;

  logic        w_idle_start;
  logic        w_redirect;
  logic        w_start;

  // A start cycle drives if_addr_in directly (byte 0), so the registered burst begins at cnt=1
  assign w_idle_start = (r_state == S_IDLE) && bus.if_ce_in && !bus.ma_ce_flag && !r_done;
  assign w_redirect   = (r_state == S_BUSY) && bus.if_ce_in && !bus.ma_ce_flag &&
                        (bus.if_addr_in != r_addr_q);
  assign w_start      = w_idle_start || w_redirect;

  assign bus.if_inst_out = r_inst;
  assign bus.if_done_out = r_done;

  always_comb begin
    bus.mem_a       = 32'd0;
    bus.mem_wr      = 1'b0;
    bus.mem_dout    = 8'd0;
    bus.ma_data_out = 8'd0;
    if (rst) begin
      bus.ma_data_out = bus.mem_din;
      if (bus.ma_ce_flag) begin
        bus.mem_a    = bus.ma_addr_in;
        bus.mem_wr   = bus.ma_rw_flag;
        bus.mem_dout = bus.ma_data_in;
      end else if (w_start) begin
        bus.mem_a = bus.if_addr_in;
      end else if ((r_state == S_BUSY) && (r_cnt <= 3'd3)) begin
        bus.mem_a = r_addr_q + {29'd0, r_cnt};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_addr_q <= 32'd0;
      r_buf    <= 24'd0;
      r_inst   <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_idle_start) begin
          r_state  <= S_BUSY;
          r_cnt    <= 3'd1;
          r_addr_q <= bus.if_addr_in;
        end
      end else if (bus.ma_ce_flag || !bus.if_ce_in) begin
        r_state <= S_IDLE;
        r_cnt   <= 3'd0;
        r_buf   <= 24'd0;
      end else if (w_redirect) begin
        r_cnt    <= 3'd1;
        r_addr_q <= bus.if_addr_in;
      end else if (r_cnt == 3'd4) begin
        r_inst  <= {bus.mem_din, r_buf};
        r_done  <= 1'b1;
        r_state <= S_IDLE;
        r_cnt   <= 3'd0;
      end else begin
        // mem_din now carries the byte addressed one cycle earlier
        case (r_cnt)
          3'd1:    r_buf[7:0]   <= bus.mem_din;
          3'd2:    r_buf[15:8]  <= bus.mem_din;
          default: r_buf[23:16] <= bus.mem_din;
        endcase
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end
endmodule
